iq_collapse_queue: RTL
======================

IQ_COLLAPSE_QUEUE -- requirements
Module: iq_collapse_queue

Interface
REQ-001 Parameter DEPTH, default 16, is the number of queue entries; legal range 4..64.
REQ-002 Parameter ISSUE_W, default 4, is the number of oldest entries in the issue window; legal range 1..DEPTH.
REQ-003 Parameter DISP_W, default 4, is the number of dispatch lanes; legal range 1..DEPTH.
REQ-004 Parameter DATA_W, default 32, is the payload width per entry.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- disp_valid  in  DISP_W  per-lane dispatch request.
- disp_data  in  DISP_W*DATA_W  lane payloads; lane i at bits [i*DATA_W +: DATA_W].
- disp_ready  out  1  queue can accept all DISP_W lanes this cycle.
- win_valid  out  ISSUE_W  entry i (0 = oldest) is occupied.
- win_data  out  ISSUE_W*DATA_W  payloads of window entries 0..ISSUE_W-1.
- issue_grant  in  ISSUE_W  checker feedback: entry i is issued this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty, full  out  1 each  count==0 / count==DEPTH.

Function
REQ-007 Entries SHALL be held oldest-first in slots 0..count-1, with no holes, at every clock edge.
REQ-008 win_valid, win_data, count, empty, full and disp_ready SHALL be driven directly from registers or from registered count only, with no combinational path from any input.
REQ-009 disp_ready SHALL be 1 when DEPTH-count >= DISP_W and 0 otherwise; same-cycle grants do not raise it.
REQ-010 Dispatch SHALL be accepted only when disp_ready=1; disp_valid while disp_ready=0 SHALL be dropped with no state change.
REQ-011 Accepted valid lanes SHALL be packed in ascending lane order, invalid lanes skipped, so that non-contiguous valid lanes (for example 4'b1010) occupy consecutive slots.
REQ-012 issue_grant[i] SHALL be ignored when win_valid[i]=0.
REQ-013 Let g = issue_grant & win_valid.
REQ-014 A surviving window entry j (j<ISSUE_W, g[j]=0) SHALL move to slot j - popcount(g[j-1:0]).
REQ-015 An entry j>=ISSUE_W SHALL move to slot j - popcount(g).
REQ-016 Granted entries SHALL be removed.
REQ-017 Newly dispatched entries SHALL be written starting at slot count - popcount(g), in the same cycle as removal.
REQ-018 Next count SHALL equal count - popcount(g) + number of accepted lanes.
REQ-019 Simultaneous issue and dispatch on a full queue: dispatch is refused (REQ-009) and issue proceeds.
REQ-020 Latency: an entry dispatched at edge N SHALL be visible in the window at N+1 if its slot is < ISSUE_W.
REQ-021 Vacated slots SHALL have valid cleared; their data is don't-care.

Reset
REQ-022 While rst=1, all valid bits and count SHALL be 0, empty=1, full=0, disp_ready=1, win_data=0, and all stored data SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-024 The first accepting edge after rst deassertion SHALL behave as on an empty queue.

Configuration
REQ-025 With macro IQ_COLLAPSE_FLUSH_EN defined, an extra input port flush (1 bit) SHALL exist.
REQ-026 When flush=1 at an edge, all entries SHALL be invalidated and count set to 0, with priority over grants and dispatch in that cycle; flush=1 does not change disp_ready.
REQ-027 Without IQ_COLLAPSE_FLUSH_EN, the flush port SHALL be absent and behaviour SHALL be exactly REQ-007..REQ-024.

Verification
REQ-028 Reset, then dispatch disp_valid=4'b1111 with payloads A,B,C,D -> next cycle count=4, win_valid=4'b1111, win_data order A,B,C,D.
REQ-029 With queue A..H (count=8), issue_grant=4'b0101 -> next cycle window B,D,E,F and count=6; issue_grant=4'b1111 -> window E,F,G,H and count=4.
REQ-030 With count=13 (DEPTH=16), disp_valid=4'b1111 -> disp_ready=0 and the dispatch is dropped; grant 2 entries the same cycle -> count=11, then disp_ready=1.
REQ-031 Queue A,B,C, with grant=4'b0010 and dispatch lanes 4'b1010 carrying X (lane1) and Y (lane3) -> window A,C,X,Y and count=4.
REQ-032 issue_grant=4'b1111 with count=2 -> only the 2 valid entries are removed, count=0, empty=1.
REQ-033 Assert rst asynchronously between edges with count=9 -> outputs immediately show count=0 and empty=1; with IQ_COLLAPSE_FLUSH_EN, flush together with grant and dispatch -> count=0 next cycle.

Source files
------------

// File: rtl/iq_collapse_queue.sv
// Collapsing issue queue: entries are kept oldest-first with no holes, and the oldest
// ISSUE_W are exposed as the issue window. Define IQ_COLLAPSE_FLUSH_EN to add a flush input.
module iq_collapse_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ISSUE_W = 4,
    parameter int unsigned DISP_W  = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef IQ_COLLAPSE_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic [DISP_W-1:0]           disp_valid,
    input  logic [DISP_W*DATA_W-1:0]    disp_data,
    output logic                        disp_ready,
    output logic [ISSUE_W-1:0]          win_valid,
    output logic [ISSUE_W*DATA_W-1:0]   win_data,
    input  logic [ISSUE_W-1:0]          issue_grant,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        empty,
    output logic                        full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_d;
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             valid_d;
    logic [DEPTH-1:0]             grant_x;
    logic [CNT_W-1:0]             count_q;
    logic [CNT_W-1:0]             count_d;
    logic [CNT_W-1:0]             shift;
    logic [CNT_W-1:0]             pos;
    logic [CNT_W-1:0]             base;
    logic [CNT_W-1:0]             added;
    logic                         ready_q;
    logic                         ready_d;
    logic                         empty_q;
    logic                         full_q;

    // Next-state: compact survivors, then append accepted lanes behind them
    always_comb begin
        data_d  = data_q;
        valid_d = '0;
        shift   = '0;
        pos     = '0;
        added   = '0;
        grant_x = DEPTH'(issue_grant & valid_q[ISSUE_W-1:0]);

        // shift is the running count of granted entries older than slot j;
        // grant_x is zero above the window so deeper entries move by the full total
        for (int j = 0; j < DEPTH; j++) begin
            if (valid_q[j] && !grant_x[j]) begin
                pos                     = CNT_W'(j) - shift;
                data_d[pos[IDX_W-1:0]]  = data_q[j];
                valid_d[pos[IDX_W-1:0]] = 1'b1;
            end
            if (grant_x[j]) begin
                shift = shift + CNT_W'(1);
            end
        end

        base = count_q - shift;
        for (int i = 0; i < DISP_W; i++) begin
            if (ready_q && disp_valid[i]) begin
                pos                     = base + added;
                data_d[pos[IDX_W-1:0]]  = disp_data[i*DATA_W +: DATA_W];
                valid_d[pos[IDX_W-1:0]] = 1'b1;
                added                   = added + CNT_W'(1);
            end
        end
        count_d = base + added;

`ifdef IQ_COLLAPSE_FLUSH_EN
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
`endif

        ready_d = (DEPTH - 32'(count_d)) >= DISP_W;
    end

    // State and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
            ready_q <= ready_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    assign win_valid  = valid_q[ISSUE_W-1:0];
    assign win_data   = data_q[ISSUE_W-1:0];
    assign count      = count_q;
    assign disp_ready = ready_q;
    assign empty      = empty_q;
    assign full       = full_q;

endmodule
